mem_dump_ctrl: RTL and testbench

Debug-bus initiator for the memory subsystem's check port: on command it walks a range of data-memory word addresses over `mem_check_addr`/`mem_check_data`, registers each word, and streams {address, data} pairs out on a valid/ready interface toward the debug/PDU output path (UART TX or display). It sits between the debug unit and the memory block's debug bus. It has no access to the instruction or data ports, so it never disturbs CPU execution.

---
 rtl/mem_dump_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_dump_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_ctrl.sv
// -----------------------------------------------------------------------------
// mem_dump_ctrl
//
// Debug-bus initiator for the memory subsystem's check port. On a start request
// it walks a range of data-memory word addresses over the check bus, registers
// each returned word, and streams {address, data} beats on a valid/ready
// interface toward the debug output path. It only touches the check bus, so it
// never disturbs CPU execution.
//
// Ports
//   clk             in   system clock, rising-edge active
//   rstn            in   asynchronous active-low reset
//   start           in   one-cycle dump request, sampled only when idle
//   base_addr[31:0] in   first word address, sampled with start
//   count[CNT_W-1:0]in   number of words to dump, sampled with start
//   busy            out  high whenever a dump is in progress (not idle)
//   done            out  one-cycle pulse when a dump finishes (also count = 0)
//   mem_check_addr  out  address driven onto the memory debug bus
//   mem_check_data  in   combinational read data from the memory debug bus
//   out_addr        out  address of the word currently presented
//   out_data        out  registered memory word currently presented
//   out_valid       out  stream valid
//   out_ready       in   stream ready from the consumer
//
// Per word the controller spends one cycle driving the address (SET), one
// cycle capturing the data (CAP) and at least one cycle presenting the beat
// (SEND). All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mem_dump_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [31:0]      mem_check_addr,
  input  logic [31:0]      mem_check_data,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SET  = 3'd1;
  localparam logic [2:0] ST_CAP  = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [CNT_W-1:0] REM_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q,          state_d;
  logic [31:0]      cur_q,            cur_d;
  logic [CNT_W-1:0] rem_q,            rem_d;
  logic             busy_q,           busy_d;
  logic             done_q,           done_d;
  logic [31:0]      mem_check_addr_q, mem_check_addr_d;
  logic [31:0]      out_addr_q,       out_addr_d;
  logic [31:0]      out_data_q,       out_data_d;
  logic             out_valid_q,      out_valid_d;
  logic             handshake_s;

  assign handshake_s = out_valid_q & out_ready;

  // Next-state and datapath logic for the dump sequencer
  always_comb begin
    state_d          = state_q;
    cur_d            = cur_q;
    rem_d            = rem_q;
    mem_check_addr_d = mem_check_addr_q;
    out_addr_d       = out_addr_q;
    out_data_d       = out_data_q;
    out_valid_d      = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != REM_ZERO) begin
            cur_d   = base_addr;
            rem_d   = count;
            state_d = ST_SET;
          end else begin
            // Empty dump: report completion without touching memory.
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SET: begin
        // Address goes out registered; memory data settles during CAP.
        mem_check_addr_d = cur_q;
        state_d          = ST_CAP;
      end

      ST_CAP: begin
        out_data_d  = mem_check_data;
        out_addr_d  = cur_q;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        if (handshake_s) begin
          out_valid_d = 1'b0;
          // Stop on rem = 1 so the counter never wraps below zero.
          if (rem_q == REM_ONE) begin
            state_d = ST_DONE;
          end else begin
            cur_d   = cur_q + 32'd1;
            rem_d   = rem_q - REM_ONE;
            state_d = ST_SET;
          end
        end else begin
          // Stall: beat held unchanged until the consumer takes it.
          state_d = ST_SEND;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Status flags are derived from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= ST_IDLE;
      cur_q            <= 32'd0;
      rem_q            <= REM_ZERO;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      mem_check_addr_q <= 32'd0;
      out_addr_q       <= 32'd0;
      out_data_q       <= 32'd0;
      out_valid_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_q            <= cur_d;
      rem_q            <= rem_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      mem_check_addr_q <= mem_check_addr_d;
      out_addr_q       <= out_addr_d;
      out_data_q       <= out_data_d;
      out_valid_q      <= out_valid_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_check_addr = mem_check_addr_q;
  assign out_addr       = out_addr_q;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_dump_ctrl
//
// Self-checking bench for mem_dump_ctrl. A behavioural memory answers the
// check bus; the expected beat list of each dump is computed up front from
// the address range, and cycle-level expectations come from the documented
// latencies: first beat two edges after start, next beat two edges after each
// handshake, done on the edge of the last handshake, idle one edge later.
// -----------------------------------------------------------------------------
module tb_mem_dump_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic [31:0]      mem_check_addr;
  logic [31:0]      mem_check_data;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] dm [0:255];
  bit          ident_mode = 1'b0;
  int          mem_gen = 0;

  always #5 clk = ~clk;

  mem_dump_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .base_addr      (base_addr),
    .count          (count),
    .busy           (busy),
    .done           (done),
    .mem_check_addr (mem_check_addr),
    .mem_check_data (mem_check_data),
    .out_addr       (out_addr),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  // Behavioural data memory seen through the check bus.
  function automatic logic [31:0] ref_mem(input logic [31:0] a);
    if (ident_mode) return a;
    if (a[31:8] == 24'd0) return dm[a[7:0]];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(mem_check_addr or mem_gen) mem_check_data = ref_mem(mem_check_addr);

  // Run one dump and check every cycle against the timing model.
  // rmode: 0 ready always high, 1 random ready, 2 five stall cycles on beat 2.
  // mid_start: cycle at which a spurious start is pulsed (-1 none).
  task automatic run_dump(input logic [31:0] b, input int n, input int rmode,
                          input int mid_start, input bit skip_sync,
                          output int obs_done, output int first_valid);
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [31:0] mca_hold;
    int beat, next_valid, done_edge, stall;
    bit rdy, exp_v, exp_done, exp_busy, finished;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(b + 32'(i));
      exp_d.push_back(ref_mem(b + 32'(i)));
    end
    beat = 0; next_valid = 2; stall = 0; finished = 1'b0;
    done_edge = (n == 0) ? 0 : -1;
    obs_done = -1; first_valid = -1;
    if (!skip_sync) @(negedge clk);
    mca_hold  = mem_check_addr;
    start     = 1'b1;
    base_addr = b;
    count     = n[CNT_W-1:0];
    out_ready = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c == mid_start) begin
        start = 1'b1; base_addr = 32'd0; count = 16'd5;
      end else begin
        start = 1'b0;
      end
      exp_v    = (beat < n) && (c >= next_valid);
      exp_done = (done_edge >= 0) && (c == done_edge);
      exp_busy = (done_edge < 0) || (c <= done_edge);
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("FAIL valid c=%0d got %b exp %b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_addr !== exp_a[beat] || out_data !== exp_d[beat]) begin
          errors++;
          $display("FAIL beat%0d c=%0d got (%h,%h) exp (%h,%h)", beat, c,
                   out_addr, out_data, exp_a[beat], exp_d[beat]);
        end
        checks++;
        if (mem_check_addr !== exp_a[beat]) begin
          errors++; $display("FAIL mca c=%0d got %h exp %h", c, mem_check_addr, exp_a[beat]);
        end
      end
      if (n == 0) begin
        checks++;
        if (mem_check_addr !== mca_hold) begin
          errors++; $display("FAIL mca_hold c=%0d got %h exp %h", c, mem_check_addr, mca_hold);
        end
      end
      checks++;
      if (done !== exp_done) begin
        errors++; $display("FAIL done c=%0d got %b exp %b", c, done, exp_done);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL busy c=%0d got %b exp %b", c, busy, exp_busy);
      end
      if (done === 1'b1 && obs_done < 0) obs_done = c;
      if (out_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (done_edge >= 0 && c > done_edge) begin
        finished = 1'b1;
        break;
      end
      case (rmode)
        1: rdy = ($urandom_range(0, 3) != 0);
        2: begin
          if (beat == 1 && exp_v && stall < 5) begin
            rdy = 1'b0; stall++;
          end else begin
            rdy = 1'b1;
          end
        end
        default: rdy = 1'b1;
      endcase
      out_ready = rdy;
      if (exp_v && rdy) begin
        beat++;
        next_valid = c + 3;
        if (beat == n) done_edge = c + 1;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (!finished) begin
      errors++; $display("FAIL timeout base=%h n=%0d got beats %0d exp %0d", b, n, beat, n);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; base_addr = 32'd0; count = '0; out_ready = 1'b1;
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, out_valid} !== 3'b000 || mem_check_addr !== 32'd0 ||
        out_addr !== 32'd0 || out_data !== 32'd0) begin
      errors++; $display("FAIL reset_state got busy=%b done=%b valid=%b mca=%h oa=%h od=%h exp all 0",
                         busy, done, out_valid, mem_check_addr, out_addr, out_data);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle got busy=%b done=%b valid=%b exp 0", busy, done, out_valid);
    end
  endtask

  task automatic test_basic_dump();
    int od, fv;
    run_dump(32'd4, 4, 0, -1, 1'b0, od, fv);
    checks++;
    if (od != 12) begin errors++; $display("FAIL basic_done_edge got %0d exp 12", od); end
    checks++;
    if (fv != 2) begin errors++; $display("FAIL basic_first_valid got %0d exp 2", fv); end
  endtask

  task automatic test_stall();
    int od, fv;
    run_dump(32'd4, 4, 2, -1, 1'b0, od, fv);
    checks++;
    if (od != 17) begin errors++; $display("FAIL stall_done_edge got %0d exp 17", od); end
  endtask

  task automatic test_zero_count();
    int od, fv;
    run_dump(32'h0000_0080, 0, 0, -1, 1'b0, od, fv);
    checks++;
    if (od != 0 || fv != -1) begin
      errors++; $display("FAIL zero_count got done@%0d valid@%0d exp 0,-1", od, fv);
    end
  endtask

  task automatic test_wrap();
    int od, fv;
    ident_mode = 1'b1; mem_gen++;
    run_dump(32'hFFFF_FFFF, 2, 0, -1, 1'b0, od, fv);
    checks++;
    if (od != 6) begin errors++; $display("FAIL wrap_done_edge got %0d exp 6", od); end
    ident_mode = 1'b0; mem_gen++;
  endtask

  task automatic test_start_ignored();
    int od, fv;
    run_dump(32'd4, 4, 0, 4, 1'b0, od, fv);
    checks++;
    if (od != 12) begin errors++; $display("FAIL ignored_done_edge got %0d exp 12", od); end
  endtask

  task automatic test_reset_abort();
    int od, fv;
    bit hit;
    logic [31:0] b;
    b = 32'h0000_0010 + 32'($urandom_range(0, 100));
    hit = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = b; count = 16'd4; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (out_valid === 1'b1 && out_addr === b + 32'd1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_reach_beat2 got none exp addr %h", b + 32'd1); end
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, out_valid} !== 3'b000 || mem_check_addr !== 32'd0 ||
        out_addr !== 32'd0 || out_data !== 32'd0) begin
      errors++; $display("FAIL abort_async got busy=%b done=%b valid=%b mca=%h oa=%h od=%h exp all 0",
                         busy, done, out_valid, mem_check_addr, out_addr, out_data);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL abort_no_done got done=%b busy=%b exp 0", done, busy);
      end
    end
    rstn = 1'b1;
    run_dump(32'd4, 4, 0, -1, 1'b0, od, fv);
    checks++;
    if (od != 12) begin errors++; $display("FAIL abort_redump got %0d exp 12", od); end
  endtask

  task automatic test_back_to_back();
    int od, fv;
    run_dump(32'd5, 2, 0, -1, 1'b0, od, fv);
    run_dump(32'd6, 3, 0, -1, 1'b1, od, fv);
    checks++;
    if (od != 9) begin errors++; $display("FAIL b2b_done_edge got %0d exp 9", od); end
  endtask

  task automatic test_random();
    int od, fv, n;
    logic [31:0] b;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 6);
      case ($urandom_range(0, 2))
        0: b = 32'($urandom_range(0, 250));
        1: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
        default: b = $urandom;
      endcase
      run_dump(b, n, 1, -1, 1'b0, od, fv);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dm[i] = 32'hC0DE_0000 | 32'(i);
    dm[4] = 32'h11; dm[5] = 32'h22; dm[6] = 32'h33; dm[7] = 32'h44;
    mem_gen++;
    test_reset();
    test_basic_dump();
    test_stall();
    test_zero_count();
    test_wrap();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

endmodule
